// File: rtl/counter_pkg.sv
// Shared definitions for the counter_gen block: count-mode encodings.
package counter_pkg;

  // Count-mode encodings driven on the mode input
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/prescaler_tick.sv
// Free-running N-bit prescaler that emits a registered one-cycle tick
// every 2**N clk cycles. clr restarts the period from zero.
module prescaler_tick #(
  parameter int N = 22
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  logic [N-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Next prescaler count and tick; tick fires the cycle after all-ones
  always_comb begin
    cnt_d  = cnt_q + N'(1);
    tick_d = (cnt_q == '1);
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  // Prescaler state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/counter_gen.sv
// Parametrised counter with up, down, ping-pong and hold modes, a
// synchronous clamped load, and a prescaler-driven step enable.
module counter_gen
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 22,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data,
  output logic             tc,
  output logic             dir,
  output logic             tick
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             tc_q, tc_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] load_clamped;
  logic             pp_up;
  logic             tick_w;

  // A load also restarts the prescaler so the next step is a full period away
  prescaler_tick #(
    .N(N)
  ) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .clr  (load),
    .tick (tick_w)
  );

  // Next count, direction and terminal pulse; load outranks a step
  always_comb begin
    data_d       = data_q;
    dir_d        = dir_q;
    tc_d         = 1'b0;
    load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    pp_up        = dir_q;

    if (load) begin
      data_d = load_clamped;
      if (load_clamped == ZERO_V) begin
        dir_d = 1'b1;
      end else if (load_clamped == MAX_V) begin
        dir_d = 1'b0;
      end
    end else if (tick_w && en) begin
      case (mode)
        MODE_UP: begin
          dir_d = 1'b1;
          if (data_q >= MAX_V) begin
            data_d = ZERO_V;
            tc_d   = 1'b1;
          end else begin
            data_d = data_q + ONE_V;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (data_q == ZERO_V || data_q > MAX_V) begin
            data_d = MAX_V;
            tc_d   = 1'b1;
          end else begin
            data_d = data_q - ONE_V;
          end
        end
        MODE_PP: begin
          if (data_q == ZERO_V) begin
            pp_up = 1'b1;
          end else if (data_q >= MAX_V) begin
            pp_up = 1'b0;
          end
          if (pp_up) begin
            data_d = data_q + ONE_V;
            if (data_d == MAX_V) begin
              tc_d  = 1'b1;
              dir_d = 1'b0;
            end else begin
              dir_d = 1'b1;
            end
          end else begin
            data_d = (data_q > MAX_V) ? MAX_V : (data_q - ONE_V);
            if (data_d == ZERO_V) begin
              tc_d  = 1'b1;
              dir_d = 1'b1;
            end else begin
              dir_d = 1'b0;
            end
          end
        end
        default: begin
          data_d = data_q;
          dir_d  = dir_q;
        end
      endcase
    end
  end

  // Count state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
      tc_q   <= 1'b0;
      dir_q  <= 1'b1;
    end else begin
      data_q <= data_d;
      tc_q   <= tc_d;
      dir_q  <= dir_d;
    end
  end

  assign data = data_q;
  assign tc   = tc_q;
  assign dir  = dir_q;
  assign tick = tick_w;

endmodule

// File: tb/tb_counter_gen.sv
// Directed bench for counter_gen: three instances cover up/enable/hold/load
// (MAX=15, N=2), down wrap and clamping (MAX=9, N=2) and ping-pong with a
// mid-run reset (MAX=3, N=1).
module tb_counter_gen;
  import counter_pkg::*;

  logic clk;

  logic       rstn_a, en_a, load_a, tc_a, dir_a, tick_a;
  logic [1:0] mode_a;
  logic [3:0] load_val_a, data_a;

  logic       rstn_b, en_b, load_b, tc_b, dir_b, tick_b;
  logic [1:0] mode_b;
  logic [3:0] load_val_b, data_b;

  logic       rstn_c, en_c, load_c, tc_c, dir_c, tick_c;
  logic [1:0] mode_c;
  logic [3:0] load_val_c, data_c;

  int vectors;
  int miscompares;
  int exp_data;
  int exp_tc;
  int pp_data [22] = '{0,0,1,1,2,2,3,3,2,2,1,1,0,0,1,1,2,2,3,3,2,2};

  counter_gen #(.WIDTH(4), .N(2), .MAX(15)) dut_a (
    .clk(clk), .rstn(rstn_a), .en(en_a), .mode(mode_a), .load(load_a),
    .load_val(load_val_a), .data(data_a), .tc(tc_a), .dir(dir_a), .tick(tick_a)
  );

  counter_gen #(.WIDTH(4), .N(2), .MAX(9)) dut_b (
    .clk(clk), .rstn(rstn_b), .en(en_b), .mode(mode_b), .load(load_b),
    .load_val(load_val_b), .data(data_b), .tc(tc_b), .dir(dir_b), .tick(tick_b)
  );

  counter_gen #(.WIDTH(4), .N(1), .MAX(3)) dut_c (
    .clk(clk), .rstn(rstn_c), .en(en_c), .mode(mode_c), .load(load_c),
    .load_val(load_val_c), .data(data_c), .tc(tc_c), .dir(dir_c), .tick(tick_c)
  );

  // Free-running bench clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Let the currently driven inputs take effect through one rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Directed sequence for all three instances
  initial begin
    vectors     = 0;
    miscompares = 0;

    rstn_a = 1'b0; en_a = 1'b1; mode_a = MODE_UP;   load_a = 1'b0; load_val_a = 4'd0;
    rstn_b = 1'b0; en_b = 1'b1; mode_b = MODE_DOWN; load_b = 1'b0; load_val_b = 4'd0;
    rstn_c = 1'b0; en_c = 1'b1; mode_c = MODE_PP;   load_c = 1'b0; load_val_c = 4'd0;

    // Instance A held in reset for three clocks
    for (int r = 0; r < 3; r++) begin
      applyStimulus();
      checkOutput($sformatf("A.rst.data%0d", r), 32'(data_a), 32'd0);
      checkOutput($sformatf("A.rst.tc%0d", r),   32'(tc_a),   32'd0);
      checkOutput($sformatf("A.rst.dir%0d", r),  32'(dir_a),  32'd1);
      checkOutput($sformatf("A.rst.tick%0d", r), 32'(tick_a), 32'd0);
    end
    rstn_a = 1'b1;

    // Up counting with wrap, then two lost ticks with en=0, then hold mode
    exp_data = 0;
    for (int c = 1; c <= 100; c++) begin
      en_a   = (c >= 67 && c <= 74) ? 1'b0 : 1'b1;
      mode_a = (c >= 83 && c <= 90) ? MODE_HOLD : MODE_UP;
      applyStimulus();
      exp_tc = 0;
      if ((c % 4) == 1 && c > 1 && en_a && mode_a == MODE_UP) begin
        exp_tc   = (exp_data == 15) ? 1 : 0;
        exp_data = (exp_data + 1) % 16;
      end
      checkOutput($sformatf("A.data c=%0d", c), 32'(data_a), 32'(exp_data));
      checkOutput($sformatf("A.tc c=%0d", c),   32'(tc_a),   32'(exp_tc));
      checkOutput($sformatf("A.tick c=%0d", c), 32'(tick_a), ((c % 4) == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("A.dir c=%0d", c),  32'(dir_a),  32'd1);
    end

    // Load in the same cycle as an accepted tick: load wins, prescaler restarts
    load_a = 1'b1; load_val_a = 4'd5;
    applyStimulus();
    load_a = 1'b0;
    checkOutput("A.load.data", 32'(data_a), 32'd5);
    checkOutput("A.load.tc",   32'(tc_a),   32'd0);
    checkOutput("A.load.tick", 32'(tick_a), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("A.postload.tick%0d", i), 32'(tick_a), (i == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("A.postload.data%0d", i), 32'(data_a), 32'd5);
    end
    applyStimulus();
    checkOutput("A.postload.step", 32'(data_a), 32'd6);

    // Instance B: load 2 in down mode, count to 0 and wrap to MAX=9
    rstn_b = 1'b1; load_b = 1'b1; load_val_b = 4'd2;
    applyStimulus();
    load_b = 1'b0;
    checkOutput("B.load.data", 32'(data_b), 32'd2);
    checkOutput("B.load.tc",   32'(tc_b),   32'd0);
    checkOutput("B.load.dir",  32'(dir_b),  32'd1);
    for (int i = 1; i <= 14; i++) begin
      applyStimulus();
      exp_data = (i < 5) ? 2 : (i < 9) ? 1 : (i < 13) ? 0 : 9;
      checkOutput($sformatf("B.data i=%0d", i), 32'(data_b), 32'(exp_data));
      checkOutput($sformatf("B.tc i=%0d", i),   32'(tc_b),   (i == 13) ? 32'd1 : 32'd0);
      checkOutput($sformatf("B.dir i=%0d", i),  32'(dir_b),  (i < 5) ? 32'd1 : 32'd0);
    end

    // Out-of-range load is clamped to MAX; loading 0 forces dir up
    load_b = 1'b1; load_val_b = 4'd12;
    applyStimulus();
    checkOutput("B.clamp.data", 32'(data_b), 32'd9);
    checkOutput("B.clamp.dir",  32'(dir_b),  32'd0);
    load_val_b = 4'd0;
    applyStimulus();
    load_b = 1'b0;
    checkOutput("B.load0.data", 32'(data_b), 32'd0);
    checkOutput("B.load0.dir",  32'(dir_b),  32'd1);

    // Instance C: ping-pong 0..3..0..3 from reset
    rstn_c = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      applyStimulus();
      checkOutput($sformatf("C.data c=%0d", c), 32'(data_c), 32'(pp_data[c-1]));
      checkOutput($sformatf("C.tc c=%0d", c),   32'(tc_c),
                  (c == 7 || c == 13 || c == 19) ? 32'd1 : 32'd0);
      checkOutput($sformatf("C.dir c=%0d", c),  32'(dir_c),
                  (c < 7 || (c >= 13 && c < 19)) ? 32'd1 : 32'd0);
      checkOutput($sformatf("C.tick c=%0d", c), 32'(tick_c), ((c % 2) == 0) ? 32'd1 : 32'd0);
    end

    // Reset coinciding with a tick and a load while counting down from 2
    rstn_c = 1'b0; load_c = 1'b1; load_val_c = 4'd1;
    applyStimulus();
    checkOutput("C.midrst.data", 32'(data_c), 32'd0);
    checkOutput("C.midrst.dir",  32'(dir_c),  32'd1);
    checkOutput("C.midrst.tc",   32'(tc_c),   32'd0);
    checkOutput("C.midrst.tick", 32'(tick_c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_gen.md
Name: counter_gen

Overview:
- Parametrised successor of the 8-bit free-running counter: configurable width, terminal value and count mode (up, down, ping-pong, hold), with synchronous load.
- The prescaler is an enable tick in the single `clk` domain; there is no derived clock.
- Drives LEDs or a downstream sequencer through `data`; `tc` flags each terminal event.

Parameters:
- WIDTH, 8, counter width in bits.
- N, 22, prescaler width; one count step every 2**N clk cycles (tick period).
- MAX, 2**WIDTH-1, terminal count value; legal range 1..2**WIDTH-1.

Ports:
- clk  in  1  system clock (12 MHz on board).
- rstn  in  1  synchronous active-low reset, sampled on posedge clk.
- en  in  1  count enable; a tick is consumed only when en=1.
- mode  in  2  count mode: 00 up, 01 down, 10 ping-pong, 11 hold.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value applied when load=1.
- data  out  WIDTH  registered count value.
- tc  out  1  registered one-cycle terminal-count pulse.
- dir  out  1  current direction, 1=up, 0=down (meaningful in ping-pong).
- tick  out  1  registered prescaler tick pulse; one clk cycle wide.

Behaviour:
- All state updates on posedge clk; one clock domain only.
- Reset (rstn=0 at posedge): data=0, prescaler=0, tick=0, tc=0, dir=1. Reset overrides load, en and tick.
- Prescaler: N-bit counter increments every clk. tick=1 for the single cycle after the counter reaches all-ones, giving a period of exactly 2**N clk. The prescaler free-runs regardless of en.
- Priority, highest first: reset > load > step.
- Load:
  - data <= min(load_val, MAX) in the next cycle, regardless of tick or en.
  - The prescaler clears to 0 and tc=0.
  - dir is unchanged, except a loaded value of 0 forces dir=1 and a loaded value of MAX forces dir=0.
- Step: occurs in a cycle where tick=1, en=1, load=0, rstn=1. Latency is one clk from the tick cycle to the new data.
- Up mode (00): data==MAX -> 0 with tc=1; otherwise data+1. dir=1.
- Down mode (01): data==0 -> MAX with tc=1; otherwise data-1. dir=0.
- Ping-pong mode (10):
  - dir=1: data+1. When the new value equals MAX: tc=1 and dir<=0.
  - dir=0: data-1. When the new value equals 0: tc=1 and dir<=1.
  - No value is repeated at the endpoints; the sequence is 0,1..MAX,MAX-1..0,1...
- Hold mode (11): data, dir and tc are held/zero. Prescaler keeps running.
- tc: high for exactly one clk, in the same cycle data first shows the terminal or wrapped value. It is 0 in every other cycle.
- Mode change: takes effect on the next step. No state is reset.
  - Entering ping-pong with data==MAX forces dir=0 on that step.
  - Entering ping-pong with data==0 forces dir=1.
- en=0 with tick=1: the tick is discarded, not deferred.
- Arithmetic is modulo MAX+1. Intermediate values never exceed WIDTH bits. If the value is out of range (MAX < 2**WIDTH-1 and data > MAX), the next step yields 0 in up mode and MAX in down mode.

Decomposition:
- Package counter_pkg: mode localparams (MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PP=2'b10, MODE_HOLD=2'b11).
- Sub-module prescaler_tick:
  - Parameter N; ports clk, rstn, clr, tick.
  - Free-running counter plus the registered tick pulse.
  - clr is driven by load.
- The count/direction logic stays in counter_gen.

Test Plan:
- Reset / prescaler: N=2, WIDTH=4, MAX=15, mode=00, en=1. Hold rstn=0 for 3 clk, then release.
  - data=0, tc=0, dir=1 during reset.
  - tick every 4 clk.
  - data steps 0,1,2... one clk after each tick.
  - After the tick following data=15: data=0 with tc=1 for one cycle.
- Down wrap: N=2, MAX=9, mode=01, load_val=2, pulse load.
  - data=2, then 1, 0, then 9 with tc=1.
  - load_val=12 is clamped to data=9.
- Ping-pong: N=1, MAX=3, mode=10, start from reset.
  - Sequence 0,1,2,3,2,1,0,1.
  - tc pulses on reaching 3 and on reaching 0.
  - dir is 0 after 3 and 1 after 0.
- Enable / hold: N=2, MAX=15, mode=00.
  - Drop en for 2 ticks: data frozen and those ticks are lost; the count resumes by +1 per tick after en=1.
  - mode=11 freezes data, with tc=0.
- Load priority: assert load=1, load_val=5 in the same cycle as tick=1 and en=1.
  - data=5, not old+1.
  - Prescaler restarts, so the next tick comes 2**N clk later.
- Reset mid-run: in ping-pong with dir=0, data=2, drive rstn=0 in the same cycle as a tick and load.
  - Next cycle: data=0, dir=1, tc=0, tick=0.
